// File: rtl/booth_mult_if.sv
// booth_mult_if: operand/result bundle between the control unit and the Booth multiplier.
//   RegAOut   multiplicand (signed), sampled on the load edge
//   RegBOut   multiplier (signed), sampled on the load edge
//   MultCtrl  start/hold request, held high until MultDone
//   MultDone  result valid on MultHIOut/MultLOOut
//   MultHIOut upper half of the product
//   MultLOOut lower half of the product
// master: control-unit side; slave: multiplier side.
interface booth_mult_if #(
    parameter int unsigned WIDTH = 32
);
    logic [WIDTH-1:0] RegAOut;
    logic [WIDTH-1:0] RegBOut;
    logic             MultCtrl;
    logic             MultDone;
    logic [WIDTH-1:0] MultHIOut;
    logic [WIDTH-1:0] MultLOOut;

    modport master (
        output RegAOut, RegBOut, MultCtrl,
        input  MultDone, MultHIOut, MultLOOut
    );

    modport slave (
        input  RegAOut, RegBOut, MultCtrl,
        output MultDone, MultHIOut, MultLOOut
    );
endinterface

// File: rtl/booth_mult.sv
// booth_mult: iterative signed WIDTH x WIDTH radix-2 Booth multiplier, one step per clock.
//   clock  rising-edge clock
//   reset  asynchronous active-low reset
//   bus    booth_mult_if.slave (operands, MultCtrl in; MultDone, MultHIOut, MultLOOut out)
// A load edge in idle captures the operands; WIDTH steps later the product lands in HI/LO and
// MultDone rises. Dropping MultCtrl mid-run aborts and keeps the previous HI/LO.
module booth_mult #(
    parameter int unsigned WIDTH = 32
) (
    input logic         clock,
    input logic         reset,
    booth_mult_if.slave bus
);
    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e             state_q, state_d;
    logic [WIDTH:0]     m_q, m_d;           // sign-extended multiplicand
    logic [2*WIDTH:0]   p_q, p_d;           // {upper (WIDTH+1 bits), multiplier/lower (WIDTH bits)}
    logic               qm1_q, qm1_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic [WIDTH:0]     sum;
    logic [2*WIDTH:0]   stepped;

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        p_d     = p_q;
        qm1_d   = qm1_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;

        sum = p_q[2*WIDTH:WIDTH];
        unique case ({p_q[0], qm1_q})
            2'b01:   sum = p_q[2*WIDTH:WIDTH] + m_q;
            2'b10:   sum = p_q[2*WIDTH:WIDTH] - m_q;
            default: ;
        endcase
        // Arithmetic shift right of {sum, lower}; the dropped bit becomes the new Q-1.
        stepped = {sum[WIDTH], sum, p_q[WIDTH-1:1]};

        unique case (state_q)
            StIdle: begin
                if (bus.MultCtrl) begin
                    m_d     = {bus.RegAOut[WIDTH-1], bus.RegAOut};
                    p_d     = {{(WIDTH + 1){1'b0}}, bus.RegBOut};
                    qm1_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (!bus.MultCtrl) begin
                    state_d = StIdle;
                end else begin
                    p_d   = stepped;
                    qm1_d = p_q[0];
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CntW'(WIDTH - 1)) begin
                        hi_d    = stepped[2*WIDTH-1:WIDTH];
                        lo_d    = stepped[WIDTH-1:0];
                        done_d  = 1'b1;
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                if (bus.MultCtrl) begin
                    done_d = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            m_q     <= '0;
            p_q     <= '0;
            qm1_q   <= 1'b0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            p_q     <= p_d;
            qm1_q   <= qm1_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign bus.MultDone  = done_q;
    assign bus.MultHIOut = hi_q;
    assign bus.MultLOOut = lo_q;
endmodule

// File: tb/tb_booth_mult.sv
// tb_booth_mult: directed-vector bench for booth_mult with hand-computed products.
module tb_booth_mult;
    localparam int unsigned WIDTH = 32;

    logic clock;
    logic reset;
    int   n_total;
    int   n_bad;

    booth_mult_if #(.WIDTH(WIDTH)) bus ();

    booth_mult #(.WIDTH(WIDTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle 1 time unit past it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Load a x b and wait for MultDone; scramble=1 changes the operands every cycle after load.
    task automatic run_mult(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input bit scramble);
        int n;
        bus.RegAOut  = a;
        bus.RegBOut  = b;
        bus.MultCtrl = 1'b1;
        tick();
        check_eq({tag, " done after load"}, {63'd0, bus.MultDone}, 64'd0);
        n = 0;
        while (!bus.MultDone && n < 100) begin
            if (scramble) begin
                bus.RegAOut = $urandom;
                bus.RegBOut = $urandom;
            end
            tick();
            n++;
        end
        check_eq({tag, " latency"}, 64'(n), 64'd32);
    endtask

    task automatic drop_ctrl(input string tag);
        bus.MultCtrl = 1'b0;
        tick();
        check_eq({tag, " done after drop"}, {63'd0, bus.MultDone}, 64'd0);
    endtask

    function automatic logic [63:0] prod();
        return {bus.MultHIOut, bus.MultLOOut};
    endfunction

    initial begin
        n_total      = 0;
        n_bad        = 0;
        reset        = 1'b0;
        bus.RegAOut  = '0;
        bus.RegBOut  = '0;
        bus.MultCtrl = 1'b0;
        tick();
        check_eq("reset done", {63'd0, bus.MultDone}, 64'd0);
        check_eq("reset prod", prod(), 64'd0);
        reset = 1'b1;
        tick();

        run_mult("3x5", 32'd3, 32'd5, 1'b0);
        check_eq("3x5 prod", prod(), 64'h0000_0000_0000_000F);
        drop_ctrl("3x5");
        check_eq("3x5 kept", prod(), 64'h0000_0000_0000_000F);

        run_mult("-7x6", 32'hFFFF_FFF9, 32'd6, 1'b0);
        check_eq("-7x6 prod", prod(), 64'hFFFF_FFFF_FFFF_FFD6);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("-7x6 hold done", {63'd0, bus.MultDone}, 64'd1);
            check_eq("-7x6 hold prod", prod(), 64'hFFFF_FFFF_FFFF_FFD6);
        end
        drop_ctrl("-7x6");

        run_mult("min*min", 32'h8000_0000, 32'h8000_0000, 1'b0);
        check_eq("min*min prod", prod(), 64'h4000_0000_0000_0000);
        drop_ctrl("min*min");

        run_mult("max*max", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
        check_eq("max*max prod", prod(), 64'h3FFF_FFFF_0000_0001);
        drop_ctrl("max*max");

        run_mult("0x5", 32'd0, 32'd5, 1'b0);
        check_eq("0x5 prod", prod(), 64'd0);
        drop_ctrl("0x5");

        // Abort a 2x2 after 10 run cycles; previous 3x5 result must survive.
        run_mult("3x5b", 32'd3, 32'd5, 1'b0);
        drop_ctrl("3x5b");
        bus.RegAOut  = 32'd2;
        bus.RegBOut  = 32'd2;
        bus.MultCtrl = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) tick();
        drop_ctrl("abort");
        for (int i = 0; i < 30; i++) tick();
        check_eq("abort done", {63'd0, bus.MultDone}, 64'd0);
        check_eq("abort kept", prod(), 64'h0000_0000_0000_000F);
        run_mult("2x2", 32'd2, 32'd2, 1'b0);
        check_eq("2x2 prod", prod(), 64'd4);
        drop_ctrl("2x2");

        run_mult("scramble", 32'h10, 32'h10, 1'b1);
        check_eq("scramble prod", prod(), 64'h100);
        drop_ctrl("scramble");

        // Asynchronous reset mid-run, applied between edges.
        bus.RegAOut  = 32'h1234;
        bus.RegBOut  = 32'd5;
        bus.MultCtrl = 1'b1;
        tick();
        for (int i = 0; i < 7; i++) tick();
        #2;
        reset = 1'b0;
        #1;
        check_eq("async rst done", {63'd0, bus.MultDone}, 64'd0);
        check_eq("async rst prod", prod(), 64'd0);
        tick();
        reset        = 1'b1;
        bus.MultCtrl = 1'b0;
        tick();
        run_mult("-1x-1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        check_eq("-1x-1 prod", prod(), 64'd1);
        drop_ctrl("-1x-1");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
